l1_icache_responder: RTL

- Core-facing L1 instruction cache: the responder end of the fetch request/wait interface that the pipeline controller drives.
- Accepts per-cycle fetch requests from the IF stage.
- On a hit, returns the instruction combinationally with core wait low.
- On a miss, holds core wait high while a refill FSM fetches a full line from the memory side with a request/grant + beat-valid burst protocol.
- Direct-mapped, read-only, no write port.

---
 rtl/l1_icache_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/l1_icache_responder.sv
// l1_icache_responder: direct-mapped read-only L1 I-cache with a request/grant line-refill FSM
// Optional L1IC_PERF_CNT_EN adds saturating hit/miss counters.
`timescale 1ns/1ps
module l1_icache_responder #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_wait_o,
  output logic [31:0] core_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef L1IC_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - WB - IB;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  state_t            state;
  logic [LINES-1:0]  valid_q;
  logic [TB-1:0]     tag_q [LINES];
  logic [31:0]       data_q [LINES][LINE_WORDS];
  logic [WB-1:0]     cnt, off;
  logic [IB-1:0]     idx, m_idx;
  logic [TB-1:0]     tag;
  logic              hit, idle, miss_start;
  logic              unused;
  assign unused       = ^core_addr_i[1:0];
  assign off          = core_addr_i[2 +: WB];
  assign idx          = core_addr_i[2+WB +: IB];
  assign tag          = core_addr_i[31 -: TB];
  // miss_addr lives in mem_addr_o, which is held for the whole refill
  assign m_idx        = mem_addr_o[2+WB +: IB];
  assign hit          = core_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign idle         = state == IDLE;
  assign miss_start   = idle & core_req_i & ~hit;
  assign core_wait_o  = core_req_i & ~(hit & idle);
  assign core_rdata_o = hit ? data_q[idx][off] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      valid_q    <= '0;
      cnt        <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (state)
        IDLE: if (miss_start) begin
          state        <= REQ;
          mem_req_o    <= 1'b1;
          mem_addr_o   <= {core_addr_i[31:2+WB], {(WB+2){1'b0}}};
          valid_q[idx] <= 1'b0;
        end
        REQ: if (mem_gnt_i) begin
          state     <= FILL;
          mem_req_o <= 1'b0;
          cnt       <= '0;
        end
        FILL: if (mem_rvalid_i) begin
          data_q[m_idx][cnt] <= mem_rdata_i;
          cnt                <= cnt + WB'(1);
          if (&cnt) begin
            tag_q[m_idx]   <= mem_addr_o[31 -: TB];
            valid_q[m_idx] <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef L1IC_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      hit_cnt_o  <= (hit & idle & ~&hit_cnt_o) ? hit_cnt_o + 32'd1 : hit_cnt_o;
      miss_cnt_o <= (miss_start & ~&miss_cnt_o) ? miss_cnt_o + 32'd1 : miss_cnt_o;
    end
  end
`endif
endmodule
